// File: rtl/byte_pair_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : byte_pair_word_assembler
//  Description : Rebuilds 16-bit words from a valid/ready byte stream. Pairs
//                of bytes are packed in the configured byte order and
//                presented through a one-entry output register. A flush
//                emits a padded partial word. A running counter tracks the
//                words taken by the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_pair_word_assembler #(
    parameter bit          SWAP  = 1'b1,
    parameter logic [7:0]  PAD   = 8'h00,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_partial,
    output logic [CNT_W-1:0] word_count
);

    // Assembler states: no byte held / first byte of a pair held
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_HALF  = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [7:0]       r_hold;
    logic [15:0]      r_out_data;
    logic             r_out_valid;
    logic             r_out_partial;
    logic [CNT_W-1:0] r_word_count;

    logic             w_slot_free;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_load_full;
    logic             w_load_flush;
    logic             w_load;
    logic [15:0]      w_full_word;
    logic [15:0]      w_pad_word;
    logic [15:0]      w_next_data;

    // The output slot can take a new word if empty or being drained now
    assign w_slot_free = !r_out_valid || out_ready;

    // The first byte of a pair never waits; only the completing byte is
    // held off while the output slot is blocked.
    assign w_in_ready  = (r_state == c_EMPTY) ? 1'b1 : w_slot_free;

    assign w_in_xfer   = in_valid && w_in_ready;
    assign w_out_xfer  = r_out_valid && out_ready;

    // In HALF an accepted byte always implies a free slot (see w_in_ready).
    // A byte arriving together with flush wins and the flush is discarded.
    assign w_load_full  = (r_state == c_HALF) && w_in_xfer;
    assign w_load_flush = (r_state == c_HALF) && !w_in_xfer && flush && w_slot_free;
    assign w_load       = w_load_full || w_load_flush;

    // Byte placement within the assembled word
    if (SWAP) begin : g_swap
        assign w_full_word = {in_data, r_hold};
        assign w_pad_word  = {PAD, r_hold};
    end else begin : g_noswap
        assign w_full_word = {r_hold, in_data};
        assign w_pad_word  = {r_hold, PAD};
    end

    assign w_next_data = w_load_full ? w_full_word : w_pad_word;

    // Next-state decision for the pairing state machine
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_next = c_HALF;
                end
            end
            c_HALF: begin
                if (w_load) begin
                    w_state_next = c_EMPTY;
                end
            end
            default: begin
                w_state_next = c_EMPTY;
            end
        endcase
    end

    // State register and capture of the first byte of each pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_EMPTY;
            r_hold  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if ((r_state == c_EMPTY) && w_in_xfer) begin
                r_hold <= in_data;
            end
        end
    end

    // One-entry output register; a load in the draining cycle keeps the
    // stream bubble-free, otherwise a drain empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data    <= 16'h0000;
            r_out_valid   <= 1'b0;
            r_out_partial <= 1'b0;
        end else if (w_load) begin
            r_out_data    <= w_next_data;
            r_out_valid   <= 1'b1;
            r_out_partial <= w_load_flush;
        end else if (w_out_xfer) begin
            r_out_valid   <= 1'b0;
        end
    end

    // Count words taken downstream (partial words included), wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
        end else if (w_out_xfer) begin
            r_word_count <= r_word_count + c_CNT_ONE;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_partial = r_out_partial;
    assign word_count  = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_byte_pair_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_pair_word_assembler
//  Description : Self-checking bench. Two instances (SWAP=1/PAD=EE/CNT_W=4
//                and SWAP=0/PAD=00/CNT_W=16) share one stimulus; a queue
//                model of pending bytes and words predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_pair_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy_a, rdy_b;
    logic [15:0] data_a, data_b;
    logic        vld_a, vld_b;
    logic        part_a, part_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    byte_pair_word_assembler #(.SWAP(1'b1), .PAD(8'hEE), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .flush(flush), .out_data(data_a), .out_valid(vld_a),
        .out_ready(out_ready), .out_partial(part_a), .word_count(cnt_a)
    );

    byte_pair_word_assembler #(.SWAP(1'b0), .PAD(8'h00), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_b), .flush(flush), .out_data(data_b), .out_valid(vld_b),
        .out_ready(out_ready), .out_partial(part_b), .word_count(cnt_b)
    );

    // ---------------- model: pending half byte + queue of words ----------
    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        bit         partial;
    } ent_t;

    ent_t       mq[$];
    bit         m_half = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_pops = 0;

    function automatic logic [15:0] word_a(ent_t e);
        return e.partial ? {8'hEE, e.b0} : {e.b1, e.b0};
    endfunction

    function automatic logic [15:0] word_b(ent_t e);
        return e.partial ? {e.b0, 8'h00} : {e.b0, e.b1};
    endfunction

    function automatic bit model_ready();
        return !m_half || (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_half = 1'b0;
            m_byte = 8'h00;
            m_pops = 0;
        end else begin
            bit   acc;
            bit   room;
            ent_t e;
            acc  = in_valid && model_ready();
            room = (mq.size() == 0) || out_ready;
            if (mq.size() != 0 && out_ready) begin
                void'(mq.pop_front());
                m_pops++;
            end
            if (acc) begin
                if (!m_half) begin
                    m_half = 1'b1;
                    m_byte = in_data;
                end else begin
                    e.b0 = m_byte; e.b1 = in_data; e.partial = 1'b0;
                    mq.push_back(e);
                    m_half = 1'b0;
                end
            end else if (m_half && flush && room) begin
                e.b0 = m_byte; e.b1 = 8'h00; e.partial = 1'b1;
                mq.push_back(e);
                m_half = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [15:0] ea, eb;
        bit ev;
        ev = (mq.size() != 0);
        chk("valid_a", {31'd0, vld_a}, {31'd0, ev});
        chk("valid_b", {31'd0, vld_b}, {31'd0, ev});
        chk("ready_a", {31'd0, rdy_a}, {31'd0, model_ready()});
        chk("ready_b", {31'd0, rdy_b}, {31'd0, model_ready()});
        chk("count_a", {28'd0, cnt_a}, m_pops % 16);
        chk("count_b", {16'd0, cnt_b}, m_pops % 65536);
        if (ev) begin
            ea = word_a(mq[0]);
            eb = word_b(mq[0]);
            chk("data_a", {16'd0, data_a}, {16'd0, ea});
            chk("data_b", {16'd0, data_b}, {16'd0, eb});
            chk("partial_a", {31'd0, part_a}, {31'd0, mq[0].partial});
            chk("partial_b", {31'd0, part_b}, {31'd0, mq[0].partial});
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) tick();
    endtask

    // Offer one byte until accepted (bounded)
    task automatic send_byte(input logic [7:0] d);
        int   n;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            acc = rdy_a;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles", d, n);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------------------------
    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", {31'd0, vld_a}, 32'd0);
        chk("rst_data", {16'd0, data_a}, 32'd0);
        chk("rst_partial", {31'd0, part_a}, 32'd0);
        chk("rst_count", {16'd0, cnt_b}, 32'd0);
        chk("rst_ready", {31'd0, rdy_a}, 32'd1);
        tick();

        // Single word with consumer ready
        out_ready = 1'b1;
        send_byte(8'h34);
        send_byte(8'h12);
        chk("t1_data_a", {16'd0, data_a}, 32'h1234);
        chk("t1_data_b", {16'd0, data_b}, 32'h3412);
        chk("t1_partial", {31'd0, part_a}, 32'd0);
        idle(1);
        chk("t1_count_a", {28'd0, cnt_a}, 32'd1);
        chk("t1_valid_gone", {31'd0, vld_a}, 32'd0);

        // Continuous stream
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("t2_w0_b", {16'd0, data_b}, 32'hAABB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("t2_w1_b", {16'd0, data_b}, 32'hCCDD);
        chk("t2_w1_a", {16'd0, data_a}, 32'hDDCC);
        idle(1);

        // Backpressure on the completing byte
        out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        in_valid = 1'b1;
        in_data  = 8'h44;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_ready", {31'd0, rdy_a}, 32'd0);
            chk("t3_hold_data", {16'd0, data_a}, 32'h2211);
            tick();
        end
        out_ready = 1'b1;
        send_byte(8'h44);
        chk("t3_second_a", {16'd0, data_a}, 32'h4433);
        idle(1);

        // Flush of a half word, then flush while empty
        send_byte(8'h5A);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_pad_a", {16'd0, data_a}, 32'hEE5A);
        chk("t4_pad_b", {16'd0, data_b}, 32'h5A00);
        chk("t4_partial", {31'd0, part_a}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_empty_flush", {31'd0, vld_a}, 32'd0);

        // Byte and flush together complete a normal word
        send_byte(8'h01);
        flush = 1'b1;
        send_byte(8'h02);
        chk("t5_data_a", {16'd0, data_a}, 32'h0201);
        chk("t5_partial", {31'd0, part_a}, 32'd0);
        idle(1);
        chk("t5_no_extra", {31'd0, vld_a}, 32'd0);

        // Flush dropped while the output slot is blocked
        out_ready = 1'b0;
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_drop_data", {16'd0, data_a}, 32'h8877);
        out_ready = 1'b1;
        idle(1);
        send_byte(8'hAB);
        chk("t6_after_drop", {16'd0, data_a}, 32'hAB99);
        idle(1);

        // Counter wrap from a fresh reset
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(2 * i));
            send_byte(8'(2 * i + 1));
        end
        idle(1);
        chk("t7_wrap_a", {28'd0, cnt_a}, 32'd0);
        chk("t7_count_b", {16'd0, cnt_b}, 32'd16);
        send_byte(8'hF0);
        send_byte(8'hF1);
        idle(1);
        chk("t7_after_wrap_a", {28'd0, cnt_a}, 32'd1);
        chk("t7_count17_b", {16'd0, cnt_b}, 32'd17);

        // Asynchronous reset with a pending word and a held byte
        out_ready = 1'b0;
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_valid", {31'd0, vld_a}, 32'd0);
        chk("t8_rst_count", {28'd0, cnt_a}, 32'd0);
        chk("t8_rst_data", {16'd0, data_a}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send_byte(8'h5E);
        send_byte(8'h6F);
        chk("t8_fresh_a", {16'd0, data_a}, 32'h6F5E);
        chk("t8_fresh_b", {16'd0, data_b}, 32'h5E6F);
        idle(1);
        chk("t8_count_a", {28'd0, cnt_a}, 32'd1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
